// File: rtl/somador_subtrator_serial.sv
// Digit-serial unsigned add/subtract unit: DIGIT bits per clock, LSB first, start/done handshake.
// Define SOMSUB_OVF_EN to add the signed-overflow output ovf.
module somador_subtrator_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SOMSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("somador_subtrator_serial: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               op_q, op_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT-1:0]       slice;
    logic                   slice_cy;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   accept;

`ifdef SOMSUB_OVF_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    // One DIGIT-wide slice; the carry (add) or borrow (sub) ripples through its bits.
    always_comb begin
        logic c;
        c     = cy_q;
        slice = '0;
        for (int i = 0; i < DIGIT; i++) begin
            slice[i] = a_q[i] ^ b_q[i] ^ c;
            if (op_q)
                c = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
            else
                c = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & c);
        end
        slice_cy = c;
    end

    // New digit enters at the MSB end so after NDIG shifts the LSB digit sits at bit 0.
    assign res_cat  = {slice, res_q};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign accept   = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
`ifdef SOMSUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_next;
                cy_d  = slice_cy;
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef SOMSUB_OVF_EN
                    ovf_d = op_q ? ((sa_q != sb_q) && (res_next[WIDTH-1] != sa_q))
                                 : ((sa_q == sb_q) && (res_next[WIDTH-1] != sa_q));
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A start in DONE is taken exactly like one in IDLE, giving back-to-back operation.
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            op_d    = op;
            cy_d    = 1'b0;
            cnt_d   = CNT_LAST;
`ifdef SOMSUB_OVF_EN
            sa_d    = a[WIDTH-1];
            sb_d    = b[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SOMSUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
`ifdef SOMSUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cy_q;
`ifdef SOMSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Scoreboard bench for somador_subtrator_serial (WIDTH=8 with DIGIT=1, 4 and 8 instances).
// Checks ovf as well when compiled with SOMSUB_OVF_EN.
module tb_somador_subtrator_serial;

    localparam int W    = 8;
    localparam int NDIG = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0, op = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    logic         start4 = 1'b0, op4 = 1'b0;
    logic [W-1:0] a4 = '0, b4 = '0;
    logic         busy4, done4, cout4;
    logic [W-1:0] res4;

    logic         start8 = 1'b0, op8 = 1'b0;
    logic [W-1:0] a8 = '0, b8 = '0;
    logic         busy8, done8, cout8;
    logic [W-1:0] res8;

`ifdef SOMSUB_OVF_EN
    logic ovf, ovf4, ovf8;
`endif

    somador_subtrator_serial #(.WIDTH(W), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef SOMSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    somador_subtrator_serial #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4)
`ifdef SOMSUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    somador_subtrator_serial #(.WIDTH(W), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8)
`ifdef SOMSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         ov;
        int unsigned  due;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0, fails = 0;
    int          pushed = 0, aborted = 0, dones = 0;
    int unsigned cyc = 0;
    logic        hold_ok = 1'b0;
    logic [W-1:0] last_res = '0;
    logic        last_cy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        logic [W:0] full;
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o) begin
            e.res = x - y;
            e.cy  = (x < y);
            s     = sx - sy;
        end else begin
            full  = {1'b0, x} + {1'b0, y};
            e.res = full[W-1:0];
            e.cy  = full[W];
            s     = sx + sy;
        end
        e.ov  = (s > longint'(2**(W-1) - 1)) || (s < -longint'(2**(W-1)));
        e.due = 0;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_ok <= 1'b0;
        end else if (done) begin
            dones++;
            check("busy_in_done", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cout", 32'(cout), 32'(e.cy));
`ifdef SOMSUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
                check("latency_cycle", cyc, e.due);
                last_res = result;
                last_cy  = cout;
                hold_ok  <= 1'b1;
            end
        end else if (!busy && hold_ok) begin
            check("hold_result", 32'(result), 32'(last_res));
            check("hold_cout", 32'(cout), 32'(last_cy));
        end
    end

    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e     = model(o, x, y);
        e.due = cyc + NDIG + 1;
        exp_q.push_back(e);
        pushed++;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    // Leaves the caller at the negedge of the DONE cycle.
    task automatic to_done();
        repeat (NDIG) @(negedge clk);
    endtask

    task automatic small_op(input int sel, input logic o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input int lat);
        exp_t        e;
        int unsigned c;
        logic        seen;
        e = model(o, x, y);
        c = cyc;
        if (sel == 4) begin start4 = 1'b1; op4 = o; a4 = x; b4 = y; end
        else          begin start8 = 1'b1; op8 = o; a8 = x; b8 = y; end
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if ((sel == 4) ? done4 : done8) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL small_timeout: DIGIT=%0d got no done expected done within 20 cycles", sel);
        end else if (sel == 4) begin
            check("d4_latency", cyc - c, 32'(lat));
            check("d4_result", 32'(res4), 32'(e.res));
            check("d4_cout", 32'(cout4), 32'(e.cy));
        end else begin
            check("d8_latency", cyc - c, 32'(lat));
            check("d8_result", 32'(res8), 32'(e.res));
            check("d8_cout", 32'(cout8), 32'(e.cy));
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(2**(W-1) - 1);
            3:       return W'(2**(W-1));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SOMSUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 8'h05, 8'h03); to_done(); @(negedge clk);
        issue(1'b1, 8'h03, 8'h05); to_done(); @(negedge clk);
        issue(1'b1, 8'hA5, 8'hA5); to_done(); @(negedge clk);
        issue(1'b0, 8'hFF, 8'h01); to_done(); @(negedge clk);
        issue(1'b0, 8'h7F, 8'h01); to_done(); @(negedge clk);
        issue(1'b1, 8'h80, 8'h01); to_done(); @(negedge clk);

        // start during RUN must be ignored; then a back-to-back start in DONE.
        issue(1'b0, 8'h12, 8'h34);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 8'h00; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (NDIG - 3) @(negedge clk);
        issue(1'b1, 8'h40, 8'h41); to_done(); @(negedge clk);

        // Asynchronous reset in the middle of RUN aborts the operation.
        issue(1'b0, 8'h55, 8'h66);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold_ok = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
`ifdef SOMSUB_OVF_EN
        check("midrst_ovf", 32'(ovf), 32'd0);
`endif
        void'(exp_q.pop_back());
        aborted++;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(1'b0, 8'h21, 8'h43); to_done(); @(negedge clk);

        small_op(4, 1'b1, 8'h10, 8'h01, 3);
        small_op(8, 1'b1, 8'h10, 8'h01, 2);
        small_op(4, 1'b0, 8'hF8, 8'h09, 3);
        small_op(8, 1'b0, 8'hFF, 8'hFF, 2);
        for (int i = 0; i < 20; i++) begin
            small_op(4, 1'($urandom), pick(), pick(), 3);
            small_op(8, 1'($urandom), pick(), pick(), 2);
        end

        for (int i = 0; i < 3000; i++) begin
            issue(1'($urandom), pick(), pick());
            to_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'(pushed - aborted));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
